// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer write arbiter.
// pixel_t is sized by FB_WIDTH/FB_CWIDTH, so the arbiter's WIDTH/CWIDTH must match them.
package fb_pkg;

    localparam int FB_WIDTH   = 11;
    localparam int FB_CWIDTH  = 8;
    localparam int FB_HACTIVE = 1280;
    localparam int FB_VACTIVE = 640;
    localparam int FB_LAST_X  = FB_HACTIVE - 1;
    localparam int FB_LAST_Y  = FB_VACTIVE - 1;

    typedef enum logic {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    typedef struct packed {
        logic [FB_WIDTH-1:0]  x;
        logic [FB_WIDTH-1:0]  y;
        logic [FB_CWIDTH-1:0] color;
    } pixel_t;

    function automatic logic in_range(input logic [FB_WIDTH-1:0] x,
                                      input logic [FB_WIDTH-1:0] y,
                                      input int hactive,
                                      input int vactive);
        return (int'(x) < hactive) && (int'(y) < vactive);
    endfunction

endpackage

// File: rtl/raster_sweep.sv
// Raster x/y counter: x inner, y outer; start rewinds to (0,0), advance steps one pixel.
module raster_sweep #(
    parameter int               WIDTH  = 11,
    parameter logic [WIDTH-1:0] LAST_X = '1,
    parameter logic [WIDTH-1:0] LAST_Y = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             advance,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             last
);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == LAST_X) begin
                x <= '0;
                y <= (y == LAST_Y) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == LAST_X) && (y == LAST_Y);

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port owner: round-robin between two draw requesters, preempted by
// a full-screen clear sweep. Handshake: a pixel transfers on an edge where valid && ready.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int              WIDTH       = FB_WIDTH,
    parameter int              HACTIVE     = FB_HACTIVE,
    parameter int              VACTIVE     = FB_VACTIVE,
    parameter int              CWIDTH      = FB_CWIDTH,
    parameter logic [CWIDTH-1:0] CLEAR_COLOR = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    input  logic              req0_valid,
    input  logic [WIDTH-1:0]  req0_x,
    input  logic [WIDTH-1:0]  req0_y,
    input  logic [CWIDTH-1:0] req0_color,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [WIDTH-1:0]  req1_x,
    input  logic [WIDTH-1:0]  req1_y,
    input  logic [CWIDTH-1:0] req1_color,
    output logic              req1_ready,
    output logic              fb_we,
    output logic [WIDTH-1:0]  fb_x,
    output logic [WIDTH-1:0]  fb_y,
    output logic [CWIDTH-1:0] fb_color
);

    localparam logic [WIDTH-1:0] LAST_X = WIDTH'(HACTIVE - 1);
    localparam logic [WIDTH-1:0] LAST_Y = WIDTH'(VACTIVE - 1);

    fb_state_t state_q, state_d;
    logic      prio_q;
    logic      busy_q;
    logic      done_q;
    logic      we_q;
    pixel_t    pix_q;
    pixel_t    grant_pix;

    logic             serving;
    logic             start_clear;
    logic             in_clear;
    logic             win0, win1;
    logic             grant;
    logic             grant_ok;
    logic [WIDTH-1:0] sweep_x, sweep_y;
    logic             sweep_last;

    // busy_q stays high through the last clear write's output cycle, so drawing
    // resumes only once clear_busy has dropped.
    assign serving     = (state_q == SERVE) && !busy_q;
    assign start_clear = serving && clear_req;
    assign in_clear    = (state_q == CLEAR);

    assign win0 = req0_valid && (!req1_valid || !prio_q);
    assign win1 = req1_valid && (!req0_valid ||  prio_q);

    assign req0_ready = serving && !clear_req && win0;
    assign req1_ready = serving && !clear_req && win1;
    assign grant      = req0_ready || req1_ready;

    assign grant_pix = req1_ready ? pixel_t'{x: req1_x, y: req1_y, color: req1_color}
                                  : pixel_t'{x: req0_x, y: req0_y, color: req0_color};
    assign grant_ok  = in_range(grant_pix.x, grant_pix.y, HACTIVE, VACTIVE);

    raster_sweep #(
        .WIDTH  (WIDTH),
        .LAST_X (LAST_X),
        .LAST_Y (LAST_Y)
    ) u_sweep (
        .clk     (clk),
        .reset   (reset),
        .start   (start_clear),
        .advance (in_clear),
        .x       (sweep_x),
        .y       (sweep_y),
        .last    (sweep_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            SERVE:   if (start_clear) state_d = CLEAR;
            CLEAR:   if (sweep_last)  state_d = SERVE;
            default: state_d = SERVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SERVE;
            prio_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= start_clear || in_clear;
            done_q  <= in_clear && sweep_last;
            if (in_clear) begin
                we_q  <= 1'b1;
                pix_q <= pixel_t'{x: sweep_x, y: sweep_y, color: CLEAR_COLOR};
            end else if (grant) begin
                // Out-of-range pixels complete the handshake but never reach the RAM.
                we_q   <= grant_ok;
                prio_q <= req0_ready;
                if (grant_ok) pix_q <= grant_pix;
            end else begin
                we_q <= 1'b0;
            end
        end
    end

    assign clear_busy = busy_q;
    assign clear_done = done_q;
    assign fb_we      = we_q;
    assign fb_x       = pix_q.x;
    assign fb_y       = pix_q.y;
    assign fb_color   = pix_q.color;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter on a 4x3 screen: vector table, clear/reset sequences,
// then random traffic against a queue-based reference model.
module tb_fb_write_arbiter;

    localparam int W  = 11;
    localparam int CW = 8;
    localparam int HA = 4;
    localparam int VA = 3;

    logic          clk, reset, clear_req, clear_busy, clear_done;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [W-1:0]  req0_x, req0_y, req1_x, req1_y;
    logic [CW-1:0] req0_color, req1_color;
    logic          fb_we;
    logic [W-1:0]  fb_x, fb_y;
    logic [CW-1:0] fb_color;

    int n_checks = 0;
    int n_fail   = 0;

    fb_write_arbiter #(
        .WIDTH(W), .HACTIVE(HA), .VACTIVE(VA), .CWIDTH(CW), .CLEAR_COLOR(8'h00)
    ) dut (
        .clk(clk), .reset(reset),
        .clear_req(clear_req), .clear_busy(clear_busy), .clear_done(clear_done),
        .req0_valid(req0_valid), .req0_x(req0_x), .req0_y(req0_y),
        .req0_color(req0_color), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_x(req1_x), .req1_y(req1_y),
        .req1_color(req1_color), .req1_ready(req1_ready),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input bit we, input int x, input int y,
                             input int c, input bit busy, input bit done, input bit chk_data);
        check({tag, " fb_we"},      32'(fb_we),      32'(we));
        check({tag, " clear_busy"}, 32'(clear_busy), 32'(busy));
        check({tag, " clear_done"}, 32'(clear_done), 32'(done));
        if (chk_data) begin
            check({tag, " fb_x"},     32'(fb_x),     32'(x));
            check({tag, " fb_y"},     32'(fb_y),     32'(y));
            check({tag, " fb_color"}, 32'(fb_color), 32'(c));
        end
    endtask

    task automatic idle_inputs();
        reset = 0; clear_req = 0; req0_valid = 0; req1_valid = 0;
        req0_x = '0; req0_y = '0; req0_color = '0;
        req1_x = '0; req1_y = '0; req1_color = '0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit rst, clr, v0, v1;
        logic [W-1:0]  x0, y0, x1, y1;
        logic [CW-1:0] c0, c1;
        bit r0, r1, we, chk_data;
        int ex, ey, ec;
    } vec_t;

    function automatic vec_t mk(bit rst, bit clr, bit v0, int x0, int y0, int c0,
                                bit v1, int x1, int y1, int c1, bit r0, bit r1,
                                bit we, bit chk_data, int ex, int ey, int ec);
        vec_t v;
        v.rst = rst; v.clr = clr;
        v.v0 = v0; v.x0 = W'(x0); v.y0 = W'(y0); v.c0 = CW'(c0);
        v.v1 = v1; v.x1 = W'(x1); v.y1 = W'(y1); v.c1 = CW'(c1);
        v.r0 = r0; v.r1 = r1; v.we = we; v.chk_data = chk_data;
        v.ex = ex; v.ey = ey; v.ec = ec;
        return v;
    endfunction

    vec_t vecs[11];

    // ---------------- clear sweep sequence ----------------
    // Checks n consecutive clear writes starting at (0,0); pulses clear_req once at mid_clr.
    task automatic sweep_check(input int n, input int mid_clr);
        for (int i = 0; i < n; i++) begin
            clear_req = (i == mid_clr);
            @(negedge clk);
            check("sweep req0_ready", 32'(req0_ready), 32'd0);
            check("sweep req1_ready", 32'(req1_ready), 32'd0);
            tick();
            check_out("sweep", 1'b1, i % HA, i / HA, 0, 1'b1, (i == HA*VA-1), 1'b1);
        end
        clear_req = 0;
    endtask

    // ---------------- reference model ----------------
    logic [2*W-1:0] exp_q[$];
    bit             m_prio, m_busy, m_we, m_done, m_known;
    int             m_x, m_y, m_c;

    task automatic model_reset();
        exp_q.delete();
        m_prio = 0; m_busy = 0; m_we = 0; m_done = 0; m_known = 1;
        m_x = 0; m_y = 0; m_c = 0;
    endtask

    task automatic model_edge(input bit rst, input bit clr, input bit g0, input bit g1,
                              input int x0, input int y0, input int c0,
                              input int x1, input int y1, input int c1);
        logic [2*W-1:0] p;
        int gx, gy, gc;
        m_done = 0;
        if (rst) begin
            model_reset();
        end else if (m_busy) begin
            if (exp_q.size() > 0) begin
                p = exp_q.pop_front();
                m_we = 1; m_known = 1;
                m_x = int'(p[W-1:0]); m_y = int'(p[2*W-1:W]); m_c = 0;
                m_done = (exp_q.size() == 0);
            end else begin
                m_busy = 0; m_we = 0;
            end
        end else if (clr) begin
            for (int y = 0; y < VA; y++)
                for (int x = 0; x < HA; x++)
                    exp_q.push_back({W'(y), W'(x)});
            m_busy = 1; m_we = 0;
        end else if (g0 || g1) begin
            gx = g0 ? x0 : x1; gy = g0 ? y0 : y1; gc = g0 ? c0 : c1;
            m_prio = g0;
            if (gx < HA && gy < VA) begin
                m_we = 1; m_known = 1; m_x = gx; m_y = gy; m_c = gc;
            end else begin
                m_we = 0; m_known = 0;
            end
        end else begin
            m_we = 0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        bit e0, e1, h0, h1;

        idle_inputs();
        reset = 1;
        tick();
        tick();
        check_out("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);

        vecs[0]  = mk(1,0, 0,0,0,0,      0,0,0,0,      0,0, 0,1, 0,0,0);
        vecs[1]  = mk(0,0, 1,1,2,'h5A,   0,0,0,0,      1,0, 1,1, 1,2,'h5A);
        vecs[2]  = mk(0,0, 0,0,0,0,      0,0,0,0,      0,0, 0,1, 1,2,'h5A);
        vecs[3]  = mk(1,0, 0,0,0,0,      0,0,0,0,      0,0, 0,1, 0,0,0);
        vecs[4]  = mk(0,0, 1,0,0,'h11,   1,3,1,'h22,   1,0, 1,1, 0,0,'h11);
        vecs[5]  = mk(0,0, 1,2,1,'h33,   1,3,1,'h22,   0,1, 1,1, 3,1,'h22);
        vecs[6]  = mk(0,0, 1,2,1,'h33,   1,1,0,'h44,   1,0, 1,1, 2,1,'h33);
        vecs[7]  = mk(0,0, 1,3,2,'h55,   1,1,0,'h44,   0,1, 1,1, 1,0,'h44);
        vecs[8]  = mk(0,0, 0,0,0,0,      1,4,0,'h66,   0,1, 0,0, 0,0,0);
        vecs[9]  = mk(0,0, 1,0,3,'h77,   0,0,0,0,      1,0, 0,0, 0,0,0);
        vecs[10] = mk(0,0, 1,3,2,'hFF,   0,0,0,0,      1,0, 1,1, 3,2,'hFF);

        for (int i = 0; i < 11; i++) begin
            reset = vecs[i].rst; clear_req = vecs[i].clr;
            req0_valid = vecs[i].v0; req0_x = vecs[i].x0; req0_y = vecs[i].y0; req0_color = vecs[i].c0;
            req1_valid = vecs[i].v1; req1_x = vecs[i].x1; req1_y = vecs[i].y1; req1_color = vecs[i].c1;
            @(negedge clk);
            check($sformatf("vec%0d req0_ready", i), 32'(req0_ready), 32'(vecs[i].r0));
            check($sformatf("vec%0d req1_ready", i), 32'(req1_ready), 32'(vecs[i].r1));
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].we, vecs[i].ex, vecs[i].ey, vecs[i].ec,
                      1'b0, 1'b0, vecs[i].chk_data);
        end
        idle_inputs();

        // Clear from idle: 12 writes in raster order, then busy drops.
        clear_req = 1;
        @(negedge clk);
        check("clr3 req0_ready", 32'(req0_ready), 32'd0);
        tick();
        check_out("clr3 start", 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        sweep_check(HA*VA, -1);
        tick();
        check_out("clr3 end", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Clear beats a same-cycle draw; a mid-sweep clear_req is ignored.
        clear_req = 1; req0_valid = 1; req0_x = 2; req0_y = 2; req0_color = 8'h3C;
        @(negedge clk);
        check("clr4 req0_ready at start", 32'(req0_ready), 32'd0);
        tick();
        check_out("clr4 start", 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        sweep_check(HA*VA, 5);
        @(negedge clk);
        check("clr4 req0_ready busy tail", 32'(req0_ready), 32'd0);
        tick();
        check_out("clr4 end", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("clr4 req0_ready after", 32'(req0_ready), 32'd1);
        tick();
        check_out("clr4 draw", 1'b1, 2, 2, 'h3C, 1'b0, 1'b0, 1'b1);
        req0_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_out("clr4 no requeue", 1'b0, 2, 2, 'h3C, 1'b0, 1'b0, 1'b1);
        end

        // Reset after the 5th clear write aborts; the next clear restarts at (0,0).
        clear_req = 1;
        tick();
        clear_req = 0;
        sweep_check(5, -1);
        reset = 1;
        tick();
        check_out("clr6 reset", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
        reset = 0; clear_req = 1;
        tick();
        check_out("clr6 restart", 1'b0, 0, 0, 0, 1'b1, 1'b0, 1'b0);
        sweep_check(HA*VA, -1);
        tick();
        check_out("clr6 end", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

        // Random traffic against the reference model.
        idle_inputs();
        reset = 1;
        tick();
        model_reset();
        reset = 0;
        h0 = 0; h1 = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            reset     = ($urandom_range(0, 299) == 0);
            clear_req = ($urandom_range(0, 39) == 0);
            if (!req0_valid || h0) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_x = W'($urandom_range(0, 5)); req0_y = W'($urandom_range(0, 3));
                req0_color = CW'($urandom_range(0, 255));
            end
            if (!req1_valid || h1) begin
                req1_valid = ($urandom_range(0, 2) != 0);
                req1_x = W'($urandom_range(0, 5)); req1_y = W'($urandom_range(0, 3));
                req1_color = CW'($urandom_range(0, 255));
            end
            @(negedge clk);
            e0 = !m_busy && !clear_req && req0_valid && (!req1_valid || !m_prio);
            e1 = !m_busy && !clear_req && req1_valid && (!req0_valid ||  m_prio);
            check("rand req0_ready", 32'(req0_ready), 32'(e0));
            check("rand req1_ready", 32'(req1_ready), 32'(e1));
            h0 = e0; h1 = e1;
            tick();
            model_edge(reset, clear_req, e0, e1,
                       int'(req0_x), int'(req0_y), int'(req0_color),
                       int'(req1_x), int'(req1_y), int'(req1_color));
            check_out("rand", m_we, m_x, m_y, m_c, m_busy, m_done, m_known);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
